acc40_seq: RTL and testbench

Sequential 40-bit accumulator stage sitting directly downstream of the team's 40-bit adder datapath. It accepts a stream of 40-bit operands over a valid/ready handshake, sums them modulo 2^40 with a sticky unsigned-carry flag, and presents the registered total, term count and flags on a second valid/ready handshake once the frame's last operand is accepted. It turns the combinational add into a framed, back-pressured reduction result for downstream consumers.

---
 rtl/acc40_seq_if.sv | 27 ++
 rtl/acc40_seq.sv | 123 ++++++++++++
 tb/tb_acc40_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/acc40_seq_if.sv
// Handshake bundle for acc40_seq: operand stream in, framed reduction result out.
// The master drives operands and result acceptance; the slave is the accumulator.
interface acc40_seq_if #(
    parameter int WIDTH = 40,
    parameter int CNTW  = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             ovf_s;
    logic [CNTW-1:0]  count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, S, Cout, ovf_s, count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, S, Cout, ovf_s, count
    );
endinterface

// File: rtl/acc40_seq.sv
// Framed 40-bit accumulator: sums an operand stream mod 2^WIDTH with sticky carry/overflow.
// Optional signed-overflow tracking is compiled in only when ACC40_SIGNED_OVF_EN is defined.
module acc40_seq #(
    parameter int WIDTH = 40,
    parameter int CNTW  = 16
) (
    input logic         clk,
    input logic         reset_n,
    acc40_seq_if.slave  acc_if
);

    typedef enum logic {
        ACC  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             cout_q, cout_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH:0]   sum_ext;
    logic             beat;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + CNTW'(1);
    endfunction

    // Handshake flags depend on state only, so nothing combinational crosses the block.
    assign acc_if.in_ready  = (state_q == ACC);
    assign acc_if.out_valid = (state_q == DONE);
    assign beat             = acc_if.in_valid && (state_q == ACC);
    assign sum_ext          = {1'b0, acc_q} + {1'b0, acc_if.in_data};

    always_comb begin
        state_d = state_q;
        first_d = first_q;
        acc_d   = acc_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ACC: begin
                if (beat) begin
                    first_d = 1'b0;
                    if (first_q) begin
                        acc_d  = acc_if.in_data;
                        cout_d = 1'b0;
                        cnt_d  = CNTW'(1);
                    end else begin
                        acc_d  = sum_ext[WIDTH-1:0];
                        cout_d = cout_q | sum_ext[WIDTH];
                        cnt_d  = sat_inc(cnt_q);
                    end
                    if (acc_if.in_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (acc_if.out_ready) begin
                    state_d = ACC;
                    first_d = 1'b1;
                end
            end
            default: begin
                state_d = ACC;
                first_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ACC;
            first_q <= 1'b1;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            acc_q   <= acc_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign acc_if.S     = acc_q;
    assign acc_if.Cout  = cout_q;
    assign acc_if.count = cnt_q;

`ifdef ACC40_SIGNED_OVF_EN
    logic ovf_q, ovf_d;

    // Two's-complement overflow: equal operand signs producing a result of the other sign.
    function automatic logic signed_ovf(input logic [WIDTH-1:0] a,
                                        input logic [WIDTH-1:0] b,
                                        input logic [WIDTH-1:0] s);
        return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    endfunction

    always_comb begin
        ovf_d = ovf_q;
        if (beat) begin
            ovf_d = first_q ? 1'b0
                            : (ovf_q | signed_ovf(acc_q, acc_if.in_data, sum_ext[WIDTH-1:0]));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign acc_if.ovf_s = ovf_q;
`else
    assign acc_if.ovf_s = 1'b0;
`endif

endmodule

// File: tb/tb_acc40_seq.sv
// Directed bench for acc40_seq: vector table for ordinary frames, hand sequences for corners.
module tb_acc40_seq;

`ifdef ACC40_SIGNED_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    acc40_seq_if #(.WIDTH(40), .CNTW(16)) bus ();
    acc40_seq_if #(.WIDTH(40), .CNTW(4))  bus4 ();

    acc40_seq #(.WIDTH(40), .CNTW(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .acc_if  (bus)
    );

    acc40_seq #(.WIDTH(40), .CNTW(4)) dut4 (
        .clk     (clk),
        .reset_n (reset_n),
        .acc_if  (bus4)
    );

    typedef struct {
        logic        vld;
        logic [39:0] data;
        logic        last;
        logic        ordy;
        logic        e_ov;
        logic        e_ir;
        logic [39:0] e_s;
        logic        e_c;
        logic        e_o;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[12];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ov, input logic ir,
                             input logic [39:0] s, input logic c, input logic o,
                             input logic [15:0] cnt);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
        check({tag, ".in_ready"},  64'(bus.in_ready),  64'(ir));
        check({tag, ".S"},         64'(bus.S),         64'(s));
        check({tag, ".Cout"},      64'(bus.Cout),      64'(c));
        check({tag, ".ovf_s"},     64'(bus.ovf_s),     64'(o));
        check({tag, ".count"},     64'(bus.count),     64'(cnt));
    endtask

    task automatic drive(input logic v, input logic [39:0] d, input logic l, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
    endtask

    initial begin
        //               vld data           last ordy  ov ir S              C  ovf      count
        tbl[0]  = '{1'b1, 40'd3,          1'b0, 1'b1, 1'b0, 1'b1, 40'd15 - 40'd12, 1'b0, 1'b0, 16'd1};
        tbl[1]  = '{1'b1, 40'd5,          1'b0, 1'b1, 1'b0, 1'b1, 40'd8,           1'b0, 1'b0, 16'd2};
        tbl[2]  = '{1'b1, 40'd7,          1'b1, 1'b1, 1'b1, 1'b0, 40'd15,          1'b0, 1'b0, 16'd3};
        tbl[3]  = '{1'b0, 40'd0,          1'b0, 1'b1, 1'b0, 1'b1, 40'd15,          1'b0, 1'b0, 16'd3};
        tbl[4]  = '{1'b1, 40'hFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 40'hFF_FFFF_FFFF, 1'b0, 1'b0, 16'd1};
        tbl[5]  = '{1'b1, 40'h2,          1'b1, 1'b1, 1'b1, 1'b0, 40'h1,           1'b1, 1'b0, 16'd2};
        tbl[6]  = '{1'b0, 40'd0,          1'b0, 1'b1, 1'b0, 1'b1, 40'h1,           1'b1, 1'b0, 16'd2};
        tbl[7]  = '{1'b1, 40'h4,          1'b1, 1'b1, 1'b1, 1'b0, 40'h4,           1'b0, 1'b0, 16'd1};
        tbl[8]  = '{1'b0, 40'd0,          1'b0, 1'b1, 1'b0, 1'b1, 40'h4,           1'b0, 1'b0, 16'd1};
        tbl[9]  = '{1'b1, 40'h7F_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1, 40'h7F_FFFF_FFFF, 1'b0, 1'b0, 16'd1};
        tbl[10] = '{1'b1, 40'h1,          1'b1, 1'b1, 1'b1, 1'b0, 40'h80_0000_0000, 1'b0, OVF_EXP, 16'd2};
        tbl[11] = '{1'b0, 40'd0,          1'b0, 1'b1, 1'b0, 1'b1, 40'h80_0000_0000, 1'b0, OVF_EXP, 16'd2};

        // Reset held two cycles while a beat is offered.
        reset_n = 1'b0;
        drive(1'b1, 40'd9, 1'b1, 1'b0);
        bus4.in_valid  = 1'b0;
        bus4.in_data   = '0;
        bus4.in_last   = 1'b0;
        bus4.out_ready = 1'b0;
        tick();
        check_all("rst0", 1'b0, 1'b1, 40'd0, 1'b0, 1'b0, 16'd0);
        tick();
        reset_n = 1'b1;
        drive(1'b0, 40'd0, 1'b0, 1'b0);
        tick();
        check_all("rst1", 1'b0, 1'b1, 40'd0, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].vld, tbl[i].data, tbl[i].last, tbl[i].ordy);
            tick();
            check_all($sformatf("vec%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_s,
                      tbl[i].e_c, tbl[i].e_o, tbl[i].e_cnt);
        end

        // Back-pressure: result held while new data is offered and refused.
        drive(1'b1, 40'd10, 1'b1, 1'b0);
        tick();
        check_all("bp_last", 1'b1, 1'b0, 40'd10, 1'b0, 1'b0, 16'd1);
        drive(1'b1, 40'd99, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all($sformatf("bp_hold%0d", i), 1'b1, 1'b0, 40'd10, 1'b0, 1'b0, 16'd1);
        end
        drive(1'b1, 40'd99, 1'b1, 1'b1);
        tick();
        check_all("bp_accept", 1'b0, 1'b1, 40'd10, 1'b0, 1'b0, 16'd1);
        drive(1'b1, 40'd99, 1'b1, 1'b0);
        tick();
        check_all("bp_next", 1'b1, 1'b0, 40'd99, 1'b0, 1'b0, 16'd1);
        drive(1'b0, 40'd0, 1'b0, 1'b1);
        tick();
        check_all("bp_done", 1'b0, 1'b1, 40'd99, 1'b0, 1'b0, 16'd1);

        // Reset mid-frame discards the partial sum.
        drive(1'b1, 40'd5, 1'b0, 1'b0);
        tick();
        tick();
        check_all("mid_part", 1'b0, 1'b1, 40'd10, 1'b0, 1'b0, 16'd2);
        reset_n = 1'b0;
        tick();
        check_all("mid_rst", 1'b0, 1'b1, 40'd0, 1'b0, 1'b0, 16'd0);
        reset_n = 1'b1;
        drive(1'b1, 40'd6, 1'b1, 1'b0);
        tick();
        check_all("mid_new", 1'b1, 1'b0, 40'd6, 1'b0, 1'b0, 16'd1);
        drive(1'b0, 40'd0, 1'b0, 1'b1);
        tick();

        // Saturating count on the 4-bit counter instance.
        bus4.in_valid = 1'b1;
        bus4.in_data  = 40'd1;
        for (int i = 1; i <= 20; i++) begin
            bus4.in_last = (i == 20);
            tick();
            if (i == 15 || i == 16) begin
                check($sformatf("sat_cnt%0d", i), 64'(bus4.count), 64'd15);
            end
        end
        bus4.in_valid = 1'b0;
        bus4.in_last  = 1'b0;
        check("sat_S",     64'(bus4.S),         64'd20);
        check("sat_count", 64'(bus4.count),     64'd15);
        check("sat_ov",    64'(bus4.out_valid), 64'd1);
        check("sat_cout",  64'(bus4.Cout),      64'd0);
        bus4.out_ready = 1'b1;
        tick();
        check("sat_accept", 64'(bus4.in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
